// File: rtl/morse_pkg.sv
// Shared types, timing constants and the digit-to-Morse lookup for morse_digit_player.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StCgap
    } state_t;

    // MSB is sent first; 0 = dot, 1 = dash.
    typedef logic [4:0] code_t;

    localparam logic [1:0] DOT_UNITS  = 2'd1;
    localparam logic [1:0] DASH_UNITS = 2'd3;
    localparam logic [1:0] GAP_UNITS  = 2'd1;
    localparam logic [1:0] CGAP_UNITS = 2'd3;

    function automatic code_t digit_code(input logic [3:0] d);
        code_t c;
        case (d)
            4'd1:    c = 5'b01111;
            4'd2:    c = 5'b00111;
            4'd3:    c = 5'b00011;
            4'd4:    c = 5'b00001;
            4'd5:    c = 5'b00000;
            4'd6:    c = 5'b10000;
            4'd7:    c = 5'b11000;
            4'd8:    c = 5'b11100;
            4'd9:    c = 5'b11110;
            default: c = 5'b11111;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] mark_units(input logic dash);
        return dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter timing one Morse phase of 1 or 3 units.
module morse_unit_timer
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] units,
    output logic       expire,
    output logic       near_expire
);
    import morse_pkg::*;

    localparam int unsigned CW = $clog2(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] SHORT_LOAD = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (units == DASH_UNITS) ? LONG_LOAD : SHORT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expire      = (cnt_q == '0);
    // One cycle before the final one; lets the parent register a last-cycle flag.
    assign near_expire = (cnt_q == CW'(1));

endmodule

// File: rtl/morse_digit_player.sv
// Plays a decimal digit as timed Morse on tone. Optional one-entry request queue
// enabled by MORSE_DIGIT_PLAYER_QUEUE_EN (adds the queued output).
module morse_digit_player
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit,
    output logic       busy,
    output logic       tone,
`ifdef MORSE_DIGIT_PLAYER_QUEUE_EN
    output logic       queued,
`endif
    output logic       done
);
    import morse_pkg::*;

    state_t     state_q, state_d;
    code_t      code_q, code_d;
    logic [2:0] idx_q, idx_d;
    logic       tone_q, busy_q, done_q;

    logic       tmr_load;
    logic [1:0] tmr_units;
    logic       tmr_expire;
    logic       tmr_near_expire;

    logic       launch;
    code_t      launch_code;

`ifdef MORSE_DIGIT_PLAYER_QUEUE_EN
    logic       q_valid_q, q_valid_d;
    code_t      q_code_q, q_code_d;
`endif

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (tmr_load),
        .units       (tmr_units),
        .expire      (tmr_expire),
        .near_expire (tmr_near_expire)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        idx_d       = idx_q;
        tmr_load    = 1'b0;
        tmr_units   = DOT_UNITS;
        launch      = 1'b0;
        launch_code = code_q;
`ifdef MORSE_DIGIT_PLAYER_QUEUE_EN
        q_valid_d   = q_valid_q;
        q_code_d    = q_code_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    launch      = 1'b1;
                    launch_code = digit_code(digit);
                end
            end
            StMark: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (idx_q != 3'd0) begin
                        state_d   = StSpace;
                        tmr_units = GAP_UNITS;
                    end else begin
                        state_d   = StCgap;
                        tmr_units = CGAP_UNITS;
                    end
                end
            end
            StSpace: begin
                if (tmr_expire) begin
                    idx_d     = idx_q - 3'd1;
                    state_d   = StMark;
                    tmr_load  = 1'b1;
                    tmr_units = mark_units(code_q[idx_d]);
                end
            end
            StCgap: begin
                if (tmr_expire) begin
`ifdef MORSE_DIGIT_PLAYER_QUEUE_EN
                    if (q_valid_q) begin
                        launch      = 1'b1;
                        launch_code = q_code_q;
                        q_valid_d   = 1'b0;
                    end else
`endif
                    if (start) begin
                        // Back-to-back request: no idle cycle between characters.
                        launch      = 1'b1;
                        launch_code = digit_code(digit);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef MORSE_DIGIT_PLAYER_QUEUE_EN
        if (start && state_q != StIdle && !q_valid_q &&
            !(state_q == StCgap && tmr_expire)) begin
            q_valid_d = 1'b1;
            q_code_d  = digit_code(digit);
        end
`endif

        if (launch) begin
            code_d    = launch_code;
            idx_d     = 3'd4;
            state_d   = StMark;
            tmr_load  = 1'b1;
            tmr_units = mark_units(launch_code[4]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            idx_q   <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            tone_q  <= (state_d == StMark);
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_q == StCgap) && tmr_near_expire;
        end
    end

`ifdef MORSE_DIGIT_PLAYER_QUEUE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_valid_q <= 1'b0;
            q_code_q  <= '0;
        end else begin
            q_valid_q <= q_valid_d;
            q_code_q  <= q_code_d;
        end
    end

    assign queued = q_valid_q;
`endif

    assign tone = tone_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
